instr_issue: RTL and testbench
==============================

INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive clk cycles a synchronized button level must hold before it is accepted; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-004 trainer_dip  input  8  raw instruction word from the trainer DIP switches; asynchronous and quasi-static.
REQ-005 activate_button  input  1  raw, bouncy, asynchronous push-button; high = pressed.
REQ-006 cpu_ready  input  1  downstream CPU core can accept an instruction this cycle.
REQ-007 instr  output  8  latched instruction presented to the CPU core.
REQ-008 instr_valid  output  1  instr is valid; an issue occurs on a cycle with instr_valid and cpu_ready both high.
REQ-009 busy  output  1  high in ISSUE or RELEASE state.
REQ-010 issue_count  output  8  number of completed issues, modulo 256.
REQ-011 dropped  output  1  sticky flag: a press was detected while an instruction was still pending.

Function
REQ-012 activate_button SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use; trainer_dip SHALL pass through a 2-flop synchronizer (dip_s) of its own.
REQ-013 Debounce: counter SHALL increment each cycle sync2 differs from db_state and clear to 0 on any cycle they match.
REQ-014 Debounce: on the cycle the counter reaches DEBOUNCE_CYCLES-1 while sync2 still differs, db_state SHALL take sync2 and the counter SHALL clear.
REQ-015 Debounce: a bounce shorter than DEBOUNCE_CYCLES cycles SHALL never change db_state.
REQ-016 db_rise SHALL equal db_state AND NOT db_prev, where db_prev is db_state delayed by one cycle.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and RELEASE.
REQ-018 IDLE -> ISSUE on db_rise; on that edge instr SHALL load dip_s.
REQ-019 ISSUE: instr_valid SHALL be 1 and instr SHALL be held stable until the issue occurs.
REQ-020 ISSUE: on an issue, issue_count SHALL increment (255 wraps to 0); the next state SHALL be RELEASE if db_state=1, otherwise IDLE.
REQ-021 RELEASE -> IDLE when db_state=0; one press SHALL yield exactly one issue regardless of hold time.
REQ-022 A db_rise in ISSUE (release and re-press before acceptance) SHALL set dropped, SHALL NOT alter instr and SHALL NOT queue a second issue.
REQ-023 db_rise in ISSUE and an issue on the same cycle: the issue SHALL complete, dropped SHALL be set, and the next state SHALL be RELEASE.
REQ-024 cpu_ready while instr_valid=0 SHALL have no effect.
REQ-025 Latency: with a clean press, instr_valid SHALL first be high after rising edge k+DEBOUNCE_CYCLES+2, where edge k is the first edge at which activate_button is sampled high.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 While rst_n=0 at a clk edge, the block SHALL set: state=IDLE, instr=0x00, instr_valid=0, busy=0, issue_count=0, dropped=0, sync/dip_s regs=0, db_state=0, db_prev=0, debounce counter=0.
REQ-028 Reset asserted mid-ISSUE SHALL abandon the pending instruction with no issue and no issue_count change.
REQ-029 If the button is held through reset deassertion, the block SHALL debounce it afresh and issue it once as a new press.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Clean issue: dip=0x1E, hold button 20 cycles, cpu_ready=1 -> instr_valid high for exactly 1 cycle, first high after edge k+6; instr=0x1E; issue_count=1; busy until button debounced low.
REQ-031 Bounce rejection: button toggled high/low every 2 cycles for 12 cycles, then low -> instr_valid never asserts; db_state stays 0.
REQ-032 Backpressure: cpu_ready=0 for 10 cycles after instr_valid rises; dip changed to 0x55 meanwhile -> instr holds 0x1E and instr_valid holds high; issue occurs on the first cpu_ready=1 cycle.
REQ-033 Drop: while ISSUE is stalled (cpu_ready=0), release for 6 cycles then re-press for 6 cycles -> dropped=1, instr unchanged; after acceptance, exactly one issue and issue_count +1.
REQ-034 Wrap: perform 256 clean issues -> issue_count reads 0x00; dropped remains 0.
REQ-035 Reset mid-op: rst_n=0 for 1 cycle while in ISSUE -> on the next cycle instr_valid=0, instr=0x00, issue_count=0; with the button held, re-issue after DEBOUNCE_CYCLES+3 edges.

Source files
------------

// File: rtl/instr_issue_if.sv
// Instruction handoff bus between the issue block and the CPU core.
// master: drives instr/instr_valid and observes cpu_ready.
// slave:  CPU side; accepts instr when both instr_valid and cpu_ready are high.
interface instr_issue_if;
    logic [7:0] instr;
    logic       instr_valid;
    logic       cpu_ready;

    modport master (
        output instr,
        output instr_valid,
        input  cpu_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output cpu_ready
    );
endinterface

// File: rtl/instr_issue.sv
// Purpose: debounce a trainer push-button and issue the DIP-switch word to the CPU once per press.
// Latency: instr_valid rises DEBOUNCE_CYCLES+2 edges after the first edge sampling a clean press.
// Backpressure: instr/instr_valid hold until cpu_ready; presses arriving meanwhile set sticky dropped.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   trainer_dip       raw 8-bit instruction word (async, quasi-static)
//   activate_button   raw bouncy push-button, high = pressed
//   cpu               instr_issue_if master: instr, instr_valid out; cpu_ready in
//   busy              high while an instruction is pending or the button is still held
//   issue_count       completed issues modulo 256
//   dropped           sticky: a press arrived while an instruction was still pending
module instr_issue #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         trainer_dip,
    input  logic               activate_button,
    instr_issue_if.master      cpu,
    output logic               busy,
    output logic [7:0]         issue_count,
    output logic               dropped
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Input synchronizers
    logic       sync1;
    logic       sync2;
    logic [7:0] dip_m;
    logic [7:0] dip_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dip_m <= 8'h00;
            dip_s <= 8'h00;
        end else begin
            sync1 <= activate_button;
            sync2 <= sync1;
            dip_m <= trainer_dip;
            dip_s <= dip_m;
        end
    end

    // Debouncer: db_state only follows sync2 after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
    logic [CNT_W-1:0] db_cnt;
    logic             db_state;
    logic             db_prev;
    logic             db_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_state <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            db_prev <= db_state;
            if (sync2 == db_state) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_MAX) begin
                db_state <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign db_rise = db_state & ~db_prev;

    // Issue FSM; every output is a register updated here.
    state_t     state;
    logic [7:0] instr_q;
    logic       instr_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            instr_q       <= 8'h00;
            instr_valid_q <= 1'b0;
            busy          <= 1'b0;
            issue_count   <= 8'h00;
            dropped       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (db_rise) begin
                        state         <= ISSUE;
                        instr_q       <= dip_s;
                        instr_valid_q <= 1'b1;
                        busy          <= 1'b1;
                    end
                end

                ISSUE: begin
                    // A fresh press while still pending is flagged, never queued.
                    if (db_rise) begin
                        dropped <= 1'b1;
                    end
                    if (cpu.cpu_ready) begin
                        issue_count   <= issue_count + 8'd1;
                        instr_valid_q <= 1'b0;
                        // Still held: wait for release so one press issues once.
                        if (db_state) begin
                            state <= RELEASE;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                RELEASE: begin
                    if (!db_state) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    instr_valid_q <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

    assign cpu.instr       = instr_q;
    assign cpu.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue with DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled 1 time unit after each rising clk edge.
module tb_instr_issue;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] trainer_dip;
    logic       activate_button;
    logic       busy;
    logic [7:0] issue_count;
    logic       dropped;

    instr_issue_if cpu_if ();

    instr_issue #(.DEBOUNCE_CYCLES(D)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .trainer_dip     (trainer_dip),
        .activate_button (activate_button),
        .cpu             (cpu_if.master),
        .busy            (busy),
        .issue_count     (issue_count),
        .dropped         (dropped)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;
    int         first_valid;
    int         valid_cycles;
    int         issues;
    int         stable;
    logic [7:0] last_instr;
    logic       db_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: account for an issue on this edge, then observe post-edge outputs.
    task automatic tick();
        if (cpu_if.instr_valid && cpu_if.cpu_ready) begin
            issues++;
            last_instr = cpu_if.instr;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cpu_if.instr_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (dut.db_state) db_seen = 1'b1;
    endtask

    task automatic clear_stats();
        cyc          = -1;
        first_valid  = -1;
        valid_cycles = 0;
        issues       = 0;
        db_seen      = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30 && !cpu_if.instr_valid; i++) tick();
        check(tag, cpu_if.instr_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && busy; i++) tick();
        check(tag, busy, 0);
    endtask

    initial begin
        rst_n            = 1'b0;
        trainer_dip      = 8'h00;
        activate_button  = 1'b0;
        cpu_if.cpu_ready = 1'b0;
        clear_stats();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_instr", cpu_if.instr, 8'h00);
        check("rst_valid", cpu_if.instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_count", issue_count, 8'h00);
        check("rst_dropped", dropped, 0);

        // Clean issue: held 20 cycles, CPU always ready
        trainer_dip      = 8'h1E;
        cpu_if.cpu_ready = 1'b1;
        repeat (3) tick();
        clear_stats();
        activate_button = 1'b1;
        repeat (20) tick();
        check("clean_busy_held", busy, 1);
        activate_button = 1'b0;
        for (int i = 0; i < 30 && busy; i++) tick();
        check("clean_first_valid", first_valid, 6);
        check("clean_valid_cycles", valid_cycles, 1);
        check("clean_issues", issues, 1);
        check("clean_instr", last_instr, 8'h1E);
        check("clean_count", issue_count, 8'd1);
        check("clean_busy_fall", cyc, 26);

        // Bounce rejection: 2-cycle high/low toggling never debounces
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            activate_button = ((i / 2) % 2) == 0;
            tick();
        end
        activate_button = 1'b0;
        repeat (10) tick();
        check("bounce_valid", valid_cycles, 0);
        check("bounce_db_state", db_seen, 0);
        check("bounce_count", issue_count, 8'd1);

        // Backpressure: dip changes while stalled, instr must hold
        clear_stats();
        cpu_if.cpu_ready = 1'b0;
        trainer_dip      = 8'h1E;
        repeat (3) tick();
        activate_button = 1'b1;
        wait_valid("bp_valid_timeout");
        check("bp_instr", cpu_if.instr, 8'h1E);
        trainer_dip = 8'h55;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_if.instr_valid && cpu_if.instr == 8'h1E) stable++;
        end
        check("bp_hold", stable, 10);
        check("bp_no_issue", issues, 0);
        cpu_if.cpu_ready = 1'b1;
        tick();
        check("bp_issues", issues, 1);
        check("bp_issued_instr", last_instr, 8'h1E);
        check("bp_valid_drop", cpu_if.instr_valid, 0);
        check("bp_busy_release", busy, 1);
        check("bp_count", issue_count, 8'd2);
        activate_button = 1'b0;
        wait_idle("bp_idle_timeout");

        // Drop: release and re-press while stalled
        clear_stats();
        cpu_if.cpu_ready = 1'b0;
        trainer_dip      = 8'hA7;
        repeat (3) tick();
        activate_button = 1'b1;
        wait_valid("drop_valid_timeout");
        check("drop_clear_before", dropped, 0);
        activate_button = 1'b0;
        repeat (6) tick();
        activate_button = 1'b1;
        trainer_dip     = 8'h3C;
        repeat (6) tick();
        repeat (3) tick();
        check("drop_flag", dropped, 1);
        check("drop_instr", cpu_if.instr, 8'hA7);
        check("drop_valid", cpu_if.instr_valid, 1);
        cpu_if.cpu_ready = 1'b1;
        repeat (5) tick();
        activate_button = 1'b0;
        wait_idle("drop_idle_timeout");
        check("drop_issues", issues, 1);
        check("drop_issued_instr", last_instr, 8'hA7);
        check("drop_count", issue_count, 8'd3);
        check("drop_sticky", dropped, 1);

        // cpu_ready while idle has no effect
        clear_stats();
        repeat (5) tick();
        check("idle_ready_issues", issues, 0);
        check("idle_ready_count", issue_count, 8'd3);

        // Reset mid-ISSUE with the button held
        clear_stats();
        cpu_if.cpu_ready = 1'b0;
        trainer_dip      = 8'h66;
        repeat (3) tick();
        activate_button = 1'b1;
        wait_valid("rst_mid_valid_timeout");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_valid", cpu_if.instr_valid, 0);
        check("rst_mid_instr", cpu_if.instr, 8'h00);
        check("rst_mid_count", issue_count, 8'h00);
        check("rst_mid_dropped", dropped, 0);
        check("rst_mid_no_issue", issues, 0);
        cyc              = 0;
        first_valid      = -1;
        cpu_if.cpu_ready = 1'b1;
        wait_valid("rst_reissue_timeout");
        check("rst_reissue_edge", first_valid, D + 3);
        check("rst_reissue_instr", cpu_if.instr, 8'h66);
        tick();
        activate_button = 1'b0;
        wait_idle("rst_idle_timeout");
        check("rst_reissue_count", issue_count, 8'd1);
        check("rst_reissue_issues", issues, 1);

        // Wrap: 256 clean issues from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        trainer_dip      = 8'h01;
        cpu_if.cpu_ready = 1'b1;
        repeat (3) tick();
        clear_stats();
        for (int n = 0; n < 256; n++) begin
            activate_button = 1'b1;
            repeat (7) tick();
            activate_button = 1'b0;
            wait_idle("wrap_idle_timeout");
            if (n == 254) check("wrap_count_255", issue_count, 8'd255);
        end
        check("wrap_count", issue_count, 8'h00);
        check("wrap_issues", issues, 256);
        check("wrap_dropped", dropped, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
